// File: rtl/sensor_evt_pkg.sv
// Shared definitions for the sensor event scheduler.
// Contents: source index constants, scheduler state enum, default sizes.
package sensor_evt_pkg;

  localparam int unsigned DEF_N_SRC = 8;
  localparam int unsigned DEF_ID_W  = 3;

  localparam int unsigned SRC_AWAKING   = 0;
  localparam int unsigned SRC_TOUCHED   = 1;
  localparam int unsigned SRC_EXPECTING = 2;
  localparam int unsigned SRC_PRESSED   = 3;
  localparam int unsigned SRC_UP        = 4;
  localparam int unsigned SRC_DOWN      = 5;
  localparam int unsigned SRC_LEFT      = 6;
  localparam int unsigned SRC_RIGHT     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker for the sensor event scheduler.
// Default build: round-robin, first request strictly after i_last_grant (wrapping).
// With PRIORITY_FIXED_EN defined: fixed priority, lowest index wins, i_last_grant ignored.
// Ports:
//   i_req        request vector
//   i_last_grant index served most recently
//   o_grant      selected index (0 when no request)
//   o_any        at least one request present
module rr_pick
  import sensor_evt_pkg::*;
#(
  parameter int unsigned N_SRC = DEF_N_SRC,
  parameter int unsigned ID_W  = DEF_ID_W
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic [ID_W-1:0]  o_grant,
  output logic             o_any
);

  assign o_any = |i_req;

`ifdef PRIORITY_FIXED_EN
  logic w_unused;
  assign w_unused = ^i_last_grant;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_grant = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (i_req[ID_W'(i)]) begin
        o_grant = ID_W'(i);
      end
    end
  end
`else
  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      w_idx = (int'(i_last_grant) + k) % int'(N_SRC);
      if (!w_found && i_req[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        o_grant = ID_W'(w_idx);
      end
    end
  end
`endif

endmodule

// File: rtl/sensor_event_sched.sv
// Shares the screen's single event input between the sensor event sources.
// Rising edges on each synchronised level are latched as pending requests and
// offered one at a time over valid/ready; a hold-off window follows each accept.
// Optional macro PRIORITY_FIXED_EN switches the picker from round-robin to
// fixed priority (lowest index first).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            allows new offers (IDLE -> OFFER only)
//   i_src_lvl       raw sensor event levels
//   o_evt_valid     event offered, i_evt_ready accepts it
//   o_evt_id        index of the offered source
//   o_pending       latched, not-yet-accepted requests
//   o_overflow      sticky: edge arrived while that source was already pending
module sensor_event_sched
  import sensor_evt_pkg::*;
#(
  parameter int unsigned N_SRC       = DEF_N_SRC,
  parameter int unsigned ID_W        = DEF_ID_W,
  parameter int unsigned HOLDOFF_CYC = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [N_SRC-1:0] i_src_lvl,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [ID_W-1:0]  o_evt_id,
  output logic [N_SRC-1:0] o_pending,
  output logic             o_overflow
);

  localparam bit              HoldEn   = (HOLDOFF_CYC != 0);
  localparam logic [CNT_W-1:0] HoldLoad = HoldEn ? CNT_W'(HOLDOFF_CYC - 1) : '0;

  logic [N_SRC-1:0] r_sync1, r_sync2, r_sync3, r_edge;
  logic [N_SRC-1:0] r_pending, w_pending_nxt, w_clr;
  logic             r_overflow, w_overflow_nxt;
  sched_state_e     r_state, w_state_nxt;
  logic             r_evt_valid, w_evt_valid_nxt;
  logic [ID_W-1:0]  r_evt_id, w_evt_id_nxt;
  logic [ID_W-1:0]  r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  w_grant;
  logic             w_any;

  rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req        (r_pending),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  // Set has priority over the accept-clear, so an edge landing on the accept
  // cycle of the same source re-arms it without counting as overflow.
  always_comb begin
    w_clr = '0;
    if (r_evt_valid && i_evt_ready) begin
      w_clr[r_evt_id] = 1'b1;
    end
    w_pending_nxt  = (r_pending & ~w_clr) | r_edge;
    w_overflow_nxt = r_overflow | (|(r_edge & r_pending & ~w_clr));
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_evt_valid_nxt  = r_evt_valid;
    w_evt_id_nxt     = r_evt_id;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_en && w_any) begin
          w_evt_id_nxt    = w_grant;
          w_evt_valid_nxt = 1'b1;
          w_state_nxt     = OFFER;
        end
      end
      OFFER: begin
        // No retraction: only the accept leaves this state.
        if (i_evt_ready) begin
          w_evt_valid_nxt  = 1'b0;
          w_last_grant_nxt = r_evt_id;
          if (HoldEn) begin
            w_cnt_nxt   = HoldLoad;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_sync3      <= '0;
      r_edge       <= '0;
      r_pending    <= '0;
      r_overflow   <= 1'b0;
      r_state      <= IDLE;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_last_grant <= ID_W'(N_SRC - 1);
      r_cnt        <= '0;
    end else begin
      r_sync1      <= i_src_lvl;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_edge       <= r_sync2 & ~r_sync3;
      r_pending    <= w_pending_nxt;
      r_overflow   <= w_overflow_nxt;
      r_state      <= w_state_nxt;
      r_evt_valid  <= w_evt_valid_nxt;
      r_evt_id     <= w_evt_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_id    = r_evt_id;
  assign o_pending   = r_pending;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_sensor_event_sched.sv
// Bench for sensor_event_sched: three instances (hold-off 0, 4 and 100) share
// stimulus and are compared every cycle against a behavioural model.
module tb_sensor_event_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ready;
  logic [7:0] lvl;

  logic       d_valid [3];
  logic [2:0] d_id    [3];
  logic [7:0] d_pend  [3];
  logic       d_ovf   [3];

  int ho [3] = '{0, 4, 100};

  always #5 clk = ~clk;

  sensor_event_sched #(.HOLDOFF_CYC(0)) u_ho0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_src_lvl(lvl),
    .o_evt_valid(d_valid[0]), .i_evt_ready(ready), .o_evt_id(d_id[0]),
    .o_pending(d_pend[0]), .o_overflow(d_ovf[0])
  );
  sensor_event_sched #(.HOLDOFF_CYC(4)) u_ho4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_src_lvl(lvl),
    .o_evt_valid(d_valid[1]), .i_evt_ready(ready), .o_evt_id(d_id[1]),
    .o_pending(d_pend[1]), .o_overflow(d_ovf[1])
  );
  sensor_event_sched #(.HOLDOFF_CYC(100)) u_ho100 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_src_lvl(lvl),
    .o_evt_valid(d_valid[2]), .i_evt_ready(ready), .o_evt_id(d_id[2]),
    .o_pending(d_pend[2]), .o_overflow(d_ovf[2])
  );

  // Reference model state, one slot per instance.
  logic [7:0] m_pend  [3];
  logic       m_ovf   [3];
  logic       m_valid [3];
  logic [2:0] m_id    [3];
  logic [2:0] m_last  [3];
  int         m_idle_from [3];  // last live edge count at which the block was still busy
  logic [7:0] hist [5];         // hist[j] = level sampled j live edges ago
  int         cyc;
  int         n_cmp;
  int         n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] g;
    logic       found;
    int         j;
    g = 3'd0;
    found = 1'b0;
`ifdef PRIORITY_FIXED_EN
    j = int'(last) * 0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        g = 3'(i);
      end
    end
`else
    for (int k = 1; k <= 8; k++) begin
      j = (int'(last) + k) % 8;
      if (!found && req[j]) begin
        found = 1'b1;
        g = 3'(j);
      end
    end
`endif
    return g;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k]      = 8'h00;
      m_ovf[k]       = 1'b0;
      m_valid[k]     = 1'b0;
      m_id[k]        = 3'd0;
      m_last[k]      = 3'd7;
      m_idle_from[k] = -1;
    end
    for (int j = 0; j < 5; j++) hist[j] = 8'h00;
  endtask

  // One live clock edge: a request appears 3 edges after the level is first
  // seen high, offers start from an idle block, hold-off lasts ho[k] edges.
  task automatic model_step();
    logic [7:0] set, clr, nxt;
    logic       acc;
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = lvl;
    set = hist[3] & ~hist[4];
    for (int k = 0; k < 3; k++) begin
      acc = m_valid[k] && ready;
      clr = acc ? (8'h01 << m_id[k]) : 8'h00;
      if ((set & m_pend[k] & ~clr) != 8'h00) m_ovf[k] = 1'b1;
      nxt = (m_pend[k] & ~clr) | set;
      if (acc) begin
        m_valid[k]     = 1'b0;
        m_last[k]      = m_id[k];
        m_idle_from[k] = cyc + ho[k];
      end else if (!m_valid[k] && cyc > m_idle_from[k] && en && m_pend[k] != 8'h00) begin
        m_valid[k] = 1'b1;
        m_id[k]    = pick(m_pend[k], m_last[k]);
      end
      m_pend[k] = nxt;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("evt_valid[%0d]", k), 32'(d_valid[k]), 32'(m_valid[k]));
      check_eq($sformatf("evt_id[%0d]", k), 32'(d_id[k]), 32'(m_id[k]));
      check_eq($sformatf("pending[%0d]", k), 32'(d_pend[k]), 32'(m_pend[k]));
      check_eq($sformatf("overflow[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
    end
  endtask

  task automatic step(input logic r, input logic [7:0] l, input logic e, input logic rd);
    @(negedge clk);
    rst_n = r;
    lvl   = l;
    en    = e;
    ready = rd;
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      model_step();
    end
    #1 check_all();
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
  endtask

  initial begin
    logic [7:0] lv;
    logic [7:0] flip;
    logic       rd;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    lvl   = 8'h00;
    en    = 1'b0;
    ready = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single one-cycle pulse on source 1.
    repeat (5) step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h02, 1'b1, 1'b1);
    repeat (20) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Simultaneous requests 0, 3, 5 then 0 and 5 again.
    step(1'b1, 8'b0010_1001, 1'b1, 1'b1);
    repeat (230) step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'b0010_0001, 1'b1, 1'b1);
    repeat (120) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Source 5 then source 0 one cycle later.
    step(1'b1, 8'h20, 1'b1, 1'b1);
    step(1'b1, 8'h21, 1'b1, 1'b1);
    repeat (220) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Hold-off: source 2 then source 6 five cycles later.
    step(1'b1, 8'h04, 1'b1, 1'b1);
    repeat (4) step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h40, 1'b1, 1'b1);
    repeat (220) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Backpressure with en toggling, then accept.
    step(1'b1, 8'h08, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 8'h00, 1'(i % 2), 1'b0);
    repeat (120) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Overflow: two edges on source 4 before the accept, then one on the accept cycle.
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    repeat (10) step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    repeat (2) step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b1);
    repeat (240) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Reset mid-offer with levels held high; rearm after release.
    step(1'b1, 8'h81, 1'b1, 1'b0);
    repeat (6) step(1'b1, 8'h81, 1'b1, 1'b0);
    async_reset();
    repeat (2) step(1'b0, 8'h81, 1'b1, 1'b1);
    repeat (20) step(1'b1, 8'h81, 1'b1, 1'b1);
    repeat (220) step(1'b1, 8'h00, 1'b1, 1'b1);

    // Random traffic with varying backpressure and occasional resets.
    lv = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 15) == 0) flip[b] = 1'b1;
      end
      lv = lv ^ flip;
      rd = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'b1, lv, ($urandom_range(0, 9) != 0), rd);
      if (m_valid[1] && $urandom_range(0, 199) == 0) begin
        async_reset();
        repeat (2) step(1'b0, lv, 1'b1, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_event_sched.md
Name: sensor_event_sched

Overview:
- Scheduler that shares the screen controller's single event-input port between the eight sensor event sources: gyro awaking, touch, sonic expecting, joystick pressed/up/down/left/right.
- Detects rising edges on each source level and latches them as pending requests.
- Offers one event at a time to the screen over a valid/ready handshake, using round-robin selection.
- Enforces a hold-off window after each accepted event so screen redraws are not flooded.
- Sits between the sensor *_top blocks and screen_top inside top.

Parameters:
- N_SRC, 8, number of event sources (index order: 0 awaking, 1 touched, 2 expecting, 3 pressed, 4 up, 5 down, 6 left, 7 right).
- ID_W, 3, width of evt_id, equal to clog2(N_SRC).
- HOLDOFF_CYC, 1000000, idle cycles after each accepted event (10 ms at 100 MHz); 0 disables hold-off.
- CNT_W, 20, hold-off counter width; must satisfy HOLDOFF_CYC <= 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  scheduling enable (driven from go); 0 blocks new offers
- src_lvl  in  N_SRC  raw sensor event levels
- evt_valid  out  1  event offered to screen
- evt_ready  in  1  screen accepts the event
- evt_id  out  ID_W  index of the offered source
- pending  out  N_SRC  latched, not-yet-accepted requests
- overflow  out  1  sticky; an edge arrived while the same source was already pending

Behaviour:
- Reset (rst=0, asynchronous):
  - All of the following clear to 0: evt_valid, evt_id, pending, overflow, the sync/edge registers and the hold-off counter.
  - State goes to IDLE; last_grant goes to N_SRC-1, so index 0 is served first.
- Input path:
  - Each src_lvl bit passes through a 2-flop synchroniser, then a rising-edge detector against a third register.
  - A rising edge sets pending[i].
  - Edge on a source whose pending[i] is already 1: the edge is dropped and overflow is set. overflow clears only on reset.
- Latency: src_lvl[i] first sampled high at edge 0 → pending[i]=1 after edge 3 → evt_valid=1 after edge 4, provided the FSM is in IDLE with en=1.
- State IDLE:
  - If en=1 and pending≠0, select the first pending index strictly after last_grant, wrapping modulo N_SRC.
  - Register that index into evt_id, set evt_valid=1 and go to OFFER.
- State OFFER:
  - evt_valid and evt_id hold stable until evt_ready=1. There is no retraction, even if en falls.
  - On evt_valid && evt_ready:
    - clear pending[evt_id];
    - set last_grant=evt_id;
    - drop evt_valid the next cycle;
    - if HOLDOFF_CYC>0, load the counter with HOLDOFF_CYC-1 and go to HOLD; otherwise go to IDLE.
  - Simultaneous accept and a new edge on the same source: the set wins, pending stays 1, overflow is not set.
- State HOLD:
  - Decrement the counter each cycle.
  - At count 0, go to IDLE.
  - Edges continue to latch into pending during HOLD.
- Back-to-back throughput:
  - With HOLDOFF_CYC=0 and evt_ready tied to 1, one event is accepted every 2 cycles (OFFER, IDLE).
- en=0 behaviour:
  - Only the IDLE→OFFER transition is blocked.
  - Edge capture and the HOLD countdown continue.
- Reset mid-OFFER: the offer is discarded and all pending requests are lost.

Optional Feature:
- Macro PRIORITY_FIXED_EN.
- Defined: IDLE picks the lowest pending index (0 highest priority); last_grant is unused.
- Undefined: round-robin as specified above.
- Handshake, latency and hold-off behaviour are identical in both builds.

Decomposition:
- Package sensor_evt_pkg:
  - source index constants (SRC_AWAKING=0 … SRC_RIGHT=7);
  - state enum (IDLE, OFFER, HOLD);
  - N_SRC and ID_W defaults.
- Sub-module rr_pick:
  - combinational round-robin picker;
  - inputs: request vector and last_grant;
  - outputs: grant index and any-request flag;
  - becomes a priority encoder under PRIORITY_FIXED_EN.

Test Plan:
- Single event: HOLDOFF_CYC=4, en=1, evt_ready=1; pulse src_lvl[1] for 1 cycle → evt_valid=1 with evt_id=1 exactly 4 cycles after sampling; accepted; pending=0; no further offer for 4 cycles.
- Round-robin: HOLDOFF_CYC=0; set pending 0, 3, 5 in the same cycle; evt_ready=1 → evt_id sequence 0, 3, 5. Then pending 0 and 5 again with last_grant=5 → order 0, 5. With PRIORITY_FIXED_EN, a fresh 5-then-0 request serves 0 first.
- Backpressure: evt_ready=0 for 10 cycles while evt_valid=1 and en toggles → evt_id stays constant and evt_valid stays 1; accept on cycle 11 clears the bit.
- Overflow: two edges on src 4 before acceptance → overflow=1 and only one event is delivered. An edge coinciding with the accept cycle leaves pending[4]=1 and overflow unchanged.
- Hold-off: HOLDOFF_CYC=100; events on src 2 then src 6, 5 cycles apart → src 6 is offered only after 100 HOLD cycles; pending[6]=1 meanwhile.
- Async reset: assert rst=0 mid-OFFER, between clock edges → evt_valid, pending and overflow go to 0 immediately; after release, the first grant goes to the lowest pending index.
